ujtag_dr_responder: RTL
=======================

# ujtag_dr_responder

Fabric-side responder for the UJTAG user data-register path: accepts the JTAG strobes the UJTAG wrapper drives (uireg, udrck, udrcap, udrsh, udrupd, utdi), oversamples them in the fabric clock domain, and returns serial data on utdo. On capture it loads a fabric status word (switch inputs), shifts it out while shifting host data in, and on update drives a control word (LED override) into the fabric. It sits beside the debug core on the same UJTAG wrapper, selected by its own user IR code.

## Interface
- W, 16: width of status/control word (2..32)
- IR_CODE, 8'h55: uireg value selecting this data register
- RESET_VAL, {W{1'b0}}: ctrl_out value after reset
- clk  in  1  fabric clock; must be ≥8x udrck frequency
- urstb  in  1  reset, asynchronous, active-low
- uireg  in  8  current JTAG user instruction
- udrck  in  1  JTAG data-register clock (sampled, not used as a clock)
- udrcap  in  1  capture-DR state
- udrsh  in  1  shift-DR state
- udrupd  in  1  update-DR state
- utdi  in  1  serial data from host
- status_in  in  W  fabric word captured on capture-DR
- utdo  out  1  serial data to host
- ctrl_out  out  W  control word, written on update-DR
- ctrl_valid  out  1  one-clk pulse when ctrl_out is written
- upd_cnt  out  8  count of accepted updates, wraps 255->0
- parity_err  out  1  sticky parity failure (see Configuration)

## Operation
- Synchronizers: 2-flop on udrck, udrcap, udrsh, udrupd, utdi; uireg registered once (quasi-static). sel = (uireg_q == IR_CODE).
- Edge detect: ck_rise = sync udrck 0->1; upd_rise = sync udrupd 0->1.
- On ck_rise with sel: udrcap -> sr <= capture word; else udrsh -> sr <= {utdi_s, sr[N-1:1]} (LSB first out). Capture wins if both high.
- utdo registered: sr[0] when sel, else 0.
- On upd_rise with sel: ctrl_out <= sr[W-1:0] (value before any same-cycle shift); ctrl_valid=1 for one cycle; upd_cnt+1 mod 256.
- Capture word = status_in (N=W) or {status_in, parity} (N=W+1) per Configuration.
- No effect of any strobe when sel=0; sr holds.
- Reset: sr=0, utdo=0, ctrl_out=RESET_VAL, ctrl_valid=0, upd_cnt=0, parity_err=0, synchronizer/edge flops=0. Reset mid-shift abandons the transfer; next transfer must start with capture.

## Timing
- udrck rising at pin -> sr change: 3 clk cycles (2 sync + edge register).
- sr change -> utdo: +1 clk; utdo valid 4 clk after udrck rise, stable until next rise (≥8x ratio guarantees settled before next host sample).
- udrupd rising -> ctrl_out/ctrl_valid: 3 clk cycles.
- status_in sampled in the clk cycle ck_rise&udrcap is seen; no synchronization on status_in.
- First utdo bit after capture is status_in[0] (or parity bit with parity enabled).

## Configuration
- UJTAG_DR_PARITY_EN defined: chain N=W+1; capture loads {status_in, ^status_in} (parity in bit 0, out first). On update, received sr[0] compared to ^sr[W:1]: match -> ctrl_out <= sr[W:1], ctrl_valid, upd_cnt++; mismatch -> ctrl_out held, no pulse, parity_err set (cleared only by reset).
- Not defined: N=W, no check, parity_err tied 0.

## Test plan
- Reset: assert urstb=0 mid-run -> utdo=0, ctrl_out=RESET_VAL, upd_cnt=0 immediately (async).
- Readback: uireg=8'h55, status_in=16'hA5C3, capture + 16 shifts -> utdo sequence LSB first 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
- Write: shift in 16'h1234, pulse udrupd -> ctrl_out=16'h1234 3 clk after udrupd rise, ctrl_valid single pulse, upd_cnt=1.
- Deselect: uireg=8'h00, full capture/shift/update of 16'hFFFF -> ctrl_out unchanged, utdo=0, no ctrl_valid.
- Wrap/simultaneous: 256 updates -> upd_cnt=0; udrcap and udrsh high on same udrck rise -> capture taken.
- Parity (UJTAG_DR_PARITY_EN): shift 17 bits with wrong parity bit -> ctrl_out held, parity_err=1; correct parity after -> ctrl_out written, parity_err stays 1.

Source files
------------

// File: rtl/ujtag_dr_responder.sv
// rtl/ujtag_dr_responder.sv - UJTAG user data-register responder: status capture, serial shift, control update.
// Optional parity on the chain: define UJTAG_DR_PARITY_EN.
module ujtag_dr_responder #(
  parameter int          W         = 16,
  parameter logic [7:0]  IR_CODE   = 8'h55,
  parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         urstb,
  input  logic [7:0]   uireg,
  input  logic         udrck,
  input  logic         udrcap,
  input  logic         udrsh,
  input  logic         udrupd,
  input  logic         utdi,
  input  logic [W-1:0] status_in,
  output logic         utdo,
  output logic [W-1:0] ctrl_out,
  output logic         ctrl_valid,
  output logic [7:0]   upd_cnt,
  output logic         parity_err
);

`ifdef UJTAG_DR_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  // Strobe bundle bit order: {udrck, udrcap, udrsh, udrupd, utdi}
  logic [4:0]   sync1, sync2;
  logic         ck_d, upd_d;
  logic [7:0]   uireg_q;
  logic [N-1:0] sr;
  logic [N-1:0] cap_word;
  logic         sel, ck_rise, upd_rise;

  assign sel      = (uireg_q == IR_CODE);
  assign ck_rise  = sync2[4] & ~ck_d;
  assign upd_rise = sync2[1] & ~upd_d;

`ifdef UJTAG_DR_PARITY_EN
  logic         parity_err_q;
  logic         par_ok;
  assign cap_word   = {status_in, ^status_in};
  assign par_ok     = (sr[0] == ^sr[W:1]);
  assign parity_err = parity_err_q;
`else
  assign cap_word   = status_in;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge urstb) begin
    if (!urstb) begin
      sync1      <= '0;
      sync2      <= '0;
      ck_d       <= 1'b0;
      upd_d      <= 1'b0;
      uireg_q    <= '0;
      sr         <= '0;
      utdo       <= 1'b0;
      ctrl_out   <= RESET_VAL;
      ctrl_valid <= 1'b0;
      upd_cnt    <= '0;
`ifdef UJTAG_DR_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1      <= {udrck, udrcap, udrsh, udrupd, utdi};
      sync2      <= sync1;
      ck_d       <= sync2[4];
      upd_d      <= sync2[1];
      uireg_q    <= uireg;
      ctrl_valid <= 1'b0;

      // Capture has priority over shift when the host asserts both
      if (ck_rise && sel) begin
        if (sync2[3]) begin
          sr <= cap_word;
        end else if (sync2[2]) begin
          sr <= {sync2[0], sr[N-1:1]};
        end
      end

      utdo <= sel & sr[0];

      if (upd_rise && sel) begin
`ifdef UJTAG_DR_PARITY_EN
        if (par_ok) begin
          ctrl_out   <= sr[W:1];
          ctrl_valid <= 1'b1;
          upd_cnt    <= upd_cnt + 8'd1;
        end else begin
          parity_err_q <= 1'b1;
        end
`else
        ctrl_out   <= sr[W-1:0];
        ctrl_valid <= 1'b1;
        upd_cnt    <= upd_cnt + 8'd1;
`endif
      end
    end
  end

endmodule
